wb_sram_slave: RTL and testbench
================================

# wb_sram_slave

Wishbone B4 registered-feedback slave that terminates one master port of a `wb_interconnect` (one `sN` port) with an on-chip word-addressed SRAM. It answers classic single cycles and incrementing bursts: linear, 4-, 8- and 16-beat wrap. Out-of-range accesses are answered with ERR, so the interconnect always sees a termination.

## Interface
Parameters:
- WB_ADDR_WIDTH, 32, byte address width of the bus.
- WB_DATA_WIDTH, 32, data width; multiple of 8.
- MEM_ADDR_BITS, 10, log2 of memory depth in words (default 1024 words).
- MEM_BASE, 'h0, byte base address; must be word aligned.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rstn  input  1  reset; asynchronous assert, active-low.
- s  wb_if.slave  -  bus port, used as follows:
  - ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE are inputs.
  - DAT_R, ACK, ERR are outputs.

## Operation
- Byte lane bits: AB = log2(WB_DATA_WIDTH/8).
- off = ADR − MEM_BASE, computed modulo 2^WB_ADDR_WIDTH.
- Word index = off[MEM_ADDR_BITS+AB-1:AB].
- An access is in range iff off[WB_ADDR_WIDTH-1:MEM_ADDR_BITS+AB] == 0.
- State machine states:
  - IDLE: ACK=0, ERR=0.
  - RESP: ACK or ERR is high for the current beat.
- IDLE, on CYC&STB at an edge:
  - Latch the word index into addr counter `acnt`, and latch CTI and BTE.
  - In range: ACK<=1, and DAT_R<=mem[idx] (read data is loaded for WE=1 too; the master ignores it).
  - Out of range: ERR<=1; DAT_R is unchanged.
  - Go to RESP.
- RESP, at each edge where CYC&STB, the beat completes:
  - Write: if WE and ACK, then mem[acnt] byte lane i <= DAT_W lane i for each SEL[i]=1, using DAT_W and SEL present at that edge.
  - Continue condition: current CTI==3'b010 and no ERR this beat.
  - Continue: acnt <= next(acnt); stay in RESP. Range-check next(acnt) against MEM_BASE to choose ACK<=1 (DAT_R<=mem[next]) or ERR<=1.
  - Otherwise: ACK<=0, ERR<=0; go to IDLE. This covers CTI 000, 001, 111, reserved values, and any ERR beat.
- next(acnt), by BTE:
  - 00: acnt+1.
  - 01: acnt[1:0] increments mod 4; upper bits held.
  - 10: acnt[2:0] increments mod 8; upper bits held.
  - 11: acnt[3:0] increments mod 16; upper bits held.
- Linear overflow past the last word is out of range. That beat gets ERR, and the burst then terminates.
- RESP with STB=0 and CYC=1 (master wait state): ACK/ERR <= 0, go to IDLE, no write. The next STB restarts from the current ADR.
- CYC=0 in any state: go to IDLE; ACK/ERR <= 0 next edge; no write.
- ACK and ERR are never both 1.
- Reset (rstn=0, asynchronous):
  - State IDLE.
  - ACK=0, ERR=0, DAT_R=0, acnt=0.
  - Memory contents are not cleared.

## Timing
- Classic access: CYC&STB sampled at edge k; ACK (or ERR) high from k to k+1; low after k+1 if the master drops STB or presents the next single. Throughput is 1 transfer per 2 cycles.
- Back-to-back classic: STB held high after the ACK edge with CTI=000. The slave sees it in IDLE at k+2 and acks at k+3.
- Incrementing burst of N beats (CTI=010 for beats 1..N-1, 111 on beat N): ACK high for N consecutive cycles beginning 1 cycle after the first STB; N+1 cycles total.
- DAT_R is registered and valid in every cycle in which ACK=1.
- Write data commits at the edge ending an ACK cycle. A read of the same word issued next cycle returns the new data.
- There is no combinational path from inputs to ACK, ERR or DAT_R.
- Reset deassertion mid-burst: first access after reset starts from IDLE.

## Test plan
- Classic write then read:
  - Write 'hDEADBEEF to MEM_BASE+'h10 with SEL=4'hF.
  - Read the same address: ACK 1 cycle after STB, DAT_R='hDEADBEEF, ERR=0.
- Byte enables:
  - Write 'h11223344 to word 0, then 'hAABBCCDD with SEL=4'b0101.
  - Read word 0 -> 'h11BB33DD.
- 4-beat wrap read (BTE=01, CTI 010,010,010,111):
  - Start address word 6 (words 4..7 preloaded with 4..7).
  - Required: DAT_R sequence 6,7,4,5 on 4 consecutive ACK cycles, then ACK=0.
- Linear burst crossing top (MEM_ADDR_BITS=10, start word 1022, 4 beats):
  - Required: ACK, ACK, ERR, then ERR/ACK=0 and state IDLE.
- Out of range classic (ADR=MEM_BASE+4*1024):
  - Required: ERR=1 for 1 cycle, ACK=0, memory unchanged.
- Aborts:
  - CYC dropped mid 8-beat burst after beat 3: ACK=0 next cycle, only beats 1..3 written.
  - rstn pulsed during RESP: ACK, ERR and DAT_R all 0 immediately; memory retains data.

Source files
------------

// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 bus bundle shared by the interconnect ports and
// the SRAM slave; master/slave modports fix signal direction.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, sel, cyc, stb, we, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we, cti, bte,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_sram_slave.sv
// Registered-feedback Wishbone slave backed by a word-addressed SRAM.
// Handles classic cycles plus linear and 4/8/16-beat wrap bursts.
module wb_sram_slave #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] MEM_BASE = '0
) (
    input logic clk,
    input logic rstn,
    wb_if.slave s
);
    localparam int NB    = WB_DATA_WIDTH / 8;
    localparam int AB    = $clog2(NB);
    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam int HI    = MEM_ADDR_BITS + AB;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state, state_n;

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    logic [WB_ADDR_WIDTH-1:0] off;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic                     in_range;
    logic                     unused_bits;

    logic [MEM_ADDR_BITS-1:0] acnt, acnt_n;
    logic [1:0]               bte_q, bte_n;
    logic [MEM_ADDR_BITS:0]   nxt;

    logic                     ack, ack_n;
    logic                     err, err_n;
    logic [WB_DATA_WIDTH-1:0] dat_r;
    logic                     rd_en;
    logic [MEM_ADDR_BITS-1:0] rd_idx;
    logic                     wr_en;

    assign off         = s.adr - MEM_BASE;
    assign idx         = off[HI-1:AB];
    assign in_range    = (off[WB_ADDR_WIDTH-1:HI] == '0);
    assign unused_bits = &{1'b0, off};

    assign s.ack   = ack;
    assign s.err   = err;
    assign s.dat_r = dat_r;

    // Extra top bit of nxt is the carry out of a linear
    // increment; set means the next beat left the array.
    always_comb begin
        nxt = {1'b0, acnt};
        unique case (bte_q)
            2'b00: nxt = {1'b0, acnt} + {{MEM_ADDR_BITS{1'b0}}, 1'b1};
            2'b01: nxt[1:0] = acnt[1:0] + 2'd1;
            2'b10: nxt[2:0] = acnt[2:0] + 3'd1;
            2'b11: nxt[3:0] = acnt[3:0] + 4'd1;
            default: nxt = {1'b0, acnt};
        endcase
    end

    always_comb begin
        state_n = state;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = acnt;
        acnt_n  = acnt;
        bte_n   = bte_q;
        wr_en   = 1'b0;
        if (!s.cyc) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s.stb) begin
                        acnt_n  = idx;
                        bte_n   = s.bte;
                        state_n = RESP;
                        if (in_range) begin
                            ack_n  = 1'b1;
                            rd_en  = 1'b1;
                            rd_idx = idx;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (s.stb) begin
                        wr_en = s.we && ack;
                        if (s.cti == 3'b010 && !err) begin
                            acnt_n = nxt[MEM_ADDR_BITS-1:0];
                            if (!nxt[MEM_ADDR_BITS]) begin
                                ack_n  = 1'b1;
                                rd_en  = 1'b1;
                                rd_idx = nxt[MEM_ADDR_BITS-1:0];
                            end else begin
                                err_n = 1'b1;
                            end
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        // Wait state ends the burst; next STB
                        // restarts from the presented address.
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            ack   <= 1'b0;
            err   <= 1'b0;
            dat_r <= '0;
            acnt  <= '0;
            bte_q <= 2'b00;
        end else begin
            state <= state_n;
            ack   <= ack_n;
            err   <= err_n;
            acnt  <= acnt_n;
            bte_q <= bte_n;
            if (rd_en) begin
                dat_r <= mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_en && s.sel[i]) begin
                mem[acnt][i*8 +: 8] <= s.dat_w[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: stimulus queues expected
// terminations, a negedge monitor pops and compares them.
module tb_wb_sram_slave;
    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        logic        chk;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    exp_t q[$];
    logic [31:0] wdat [16];

    wb_if #(.AW(32), .DW(32)) bus ();

    wb_sram_slave #(
        .WB_ADDR_WIDTH(32),
        .WB_DATA_WIDTH(32),
        .MEM_ADDR_BITS(10),
        .MEM_BASE(BASE)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (rstn && bus.cyc && bus.stb && (bus.ack || bus.err)) begin
            checks++;
            if (bus.ack && bus.err) begin
                failures++;
                $display("FAIL ack_err_both actual=11 required=one-hot");
            end else if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_term actual ack=%0b err=%0b required none",
                         bus.ack, bus.err);
            end else begin
                e = q.pop_front();
                if (bus.err !== e.err ||
                    (e.chk && bus.dat_r !== e.dat)) begin
                    failures++;
                    $display("FAIL beat actual err=%0b dat=%h required err=%0b dat=%h",
                             bus.err, bus.dat_r, e.err, e.dat);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic exp_ack(input logic [31:0] d, input logic chk);
        exp_t e;
        e.err = 1'b0;
        e.dat = d;
        e.chk = chk;
        q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.err = 1'b1;
        e.dat = '0;
        e.chk = 1'b0;
        q.push_back(e);
    endtask

    function automatic logic [31:0] wa(input int w);
        return BASE + 32'(w * 4);
    endfunction

    task automatic xfer(input logic [31:0] adr, input int n,
                        input logic [1:0] bte, input logic we,
                        input logic [3:0] sel, input logic [2:0] cti_last,
                        input int abort_after);
        int   t;
        logic got;
        logic was_err;
        logic aborted;
        aborted   = 1'b0;
        bus.adr   = adr;
        bus.we    = we;
        bus.sel   = sel;
        bus.bte   = bte;
        bus.cti   = (n == 1) ? cti_last : 3'b010;
        bus.dat_w = wdat[0];
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        for (int i = 0; i < n; i++) begin
            got = 1'b0;
            t   = 0;
            while (!got && t < 8) begin
                @(negedge clk);
                if (bus.ack || bus.err) got = 1'b1;
                else t++;
            end
            if (!got) begin
                check("beat_timeout", 32'd0, 32'd1);
                break;
            end
            check("beat_latency", t, (i == 0) ? 1 : 0);
            was_err = bus.err;
            @(posedge clk);
            #1;
            if (was_err || i == n - 1) break;
            if (abort_after == i + 1) begin
                aborted = 1'b1;
                break;
            end
            bus.dat_w = wdat[i+1];
            bus.cti   = (i + 1 == n - 1) ? cti_last : 3'b010;
            bus.adr   = bus.adr + 32'd4;
        end
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        bus.cti = 3'b000;
        if (aborted) @(negedge clk);
        @(negedge clk);
        check("idle_ack", 32'(bus.ack), 32'd0);
        check("idle_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input int w, input logic [31:0] d,
                       input logic [3:0] sel);
        wdat[0] = d;
        exp_ack('0, 1'b0);
        xfer(wa(w), 1, 2'b00, 1'b1, sel, 3'b000, 0);
    endtask

    task automatic rd1(input int w, input logic [31:0] d);
        exp_ack(d, 1'b1);
        xfer(wa(w), 1, 2'b00, 1'b0, 4'hF, 3'b000, 0);
    endtask

    initial begin
        int got;
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        bus.adr   = '0;
        bus.dat_w = '0;
        bus.sel   = '0;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.cti   = 3'b000;
        bus.bte   = 2'b00;
        for (int i = 0; i < 16; i++) wdat[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_dat", bus.dat_r, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        wr1(4, 32'hDEADBEEF, 4'hF);
        rd1(4, 32'hDEADBEEF);

        wr1(0, 32'h11223344, 4'hF);
        wr1(0, 32'hAABBCCDD, 4'b0101);
        rd1(0, 32'h11BB33DD);

        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'(i + 4);
            exp_ack('0, 1'b0);
        end
        xfer(wa(4), 4, 2'b00, 1'b1, 4'hF, 3'b111, 0);
        exp_ack(32'd6, 1'b1);
        exp_ack(32'd7, 1'b1);
        exp_ack(32'd4, 1'b1);
        exp_ack(32'd5, 1'b1);
        xfer(wa(6), 4, 2'b01, 1'b0, 4'hF, 3'b111, 0);

        wr1(1022, 32'hCAFE0001, 4'hF);
        wr1(1023, 32'hCAFE0002, 4'hF);
        exp_ack(32'hCAFE0001, 1'b1);
        exp_ack(32'hCAFE0002, 1'b1);
        exp_err();
        xfer(wa(1022), 4, 2'b00, 1'b0, 4'hF, 3'b111, 0);

        wdat[0] = 32'hFFFFFFFF;
        exp_err();
        xfer(BASE + 32'h1000, 1, 2'b00, 1'b1, 4'hF, 3'b000, 0);
        exp_err();
        xfer(BASE - 32'd4, 1, 2'b00, 1'b0, 4'hF, 3'b000, 0);
        rd1(0, 32'h11BB33DD);
        rd1(1023, 32'hCAFE0002);

        wr1(35, 32'h55555555, 4'hF);
        for (int i = 0; i < 8; i++) wdat[i] = 32'hA0 + 32'(i);
        for (int i = 0; i < 3; i++) exp_ack('0, 1'b0);
        xfer(wa(32), 8, 2'b00, 1'b1, 4'hF, 3'b111, 3);
        rd1(32, 32'h000000A0);
        rd1(33, 32'h000000A1);
        rd1(34, 32'h000000A2);
        rd1(35, 32'h55555555);

        exp_ack(32'h11BB33DD, 1'b1);
        bus.adr = wa(0);
        bus.we  = 1'b0;
        bus.sel = 4'hF;
        bus.cti = 3'b000;
        bus.bte = 2'b00;
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        got = 0;
        for (int t = 0; t < 4 && got == 0; t++) begin
            @(negedge clk);
            if (bus.ack) got = 1;
        end
        check("rstpulse_ack_seen", 32'(got), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("rstpulse_ack", 32'(bus.ack), 32'd0);
        check("rstpulse_err", 32'(bus.err), 32'd0);
        check("rstpulse_dat", bus.dat_r, 32'd0);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        rd1(0, 32'h11BB33DD);
        rd1(7, 32'h00000007);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
